pipe_lsu_mem: RTL and testbench
===============================

// Module: pipe_lsu_mem
// PURPOSE
//  MEM-stage load/store unit with a built-in word-organised data RAM for the pipelined core.
//  Executes LW/LH/LB/LHU/LBU/SW/SH/SB with byte-lane steering, sign/zero extension and misalignment detection.
//  Configurable memory wait states; a stall output holds the EX/MEM pipeline register.
//  Supersedes the fixed single-cycle data memory.
// PARAMETERS
//  ADDR_W        10  word-address bits; RAM depth = 2**ADDR_W words of 32 bits
//  WAIT_CYCLES   0   extra memory latency in cycles, legal range 0..15
//  MISALIGN_TRAP 1   1: misaligned access is suppressed; 0: low address bits are forced to 0 and the access is performed
// PORTS
//  CLK        in   1   clock, rising edge
//  RST        in   1   asynchronous active-low reset
//  req_valid  in   1   MEM stage holds a load/store
//  req_ready  out  1   unit can accept a request this cycle
//  req_we     in   1   1 = store, 0 = load
//  req_size   in   2   00 byte, 01 half, 10 word, 11 illegal
//  req_signed in   1   load sign-extends when 1, zero-extends when 0
//  req_addr   in   32  byte address
//  req_wdata  in   32  store data, right-aligned (byte in [7:0], half in [15:0])
//  resp_valid out  1   one-cycle pulse: access complete
//  resp_rdata out  32  extended load data, valid with resp_valid; 0 for stores and traps
//  misalign   out  1   valid with resp_valid; request was misaligned or illegal
//  stall      out  1   req_valid & ~req_ready; drives the pipeline hold
// BEHAVIOUR
//  - Reset (RST=0, asynchronous): FSM -> IDLE; wait counter = 0.
//    resp_valid=0, resp_rdata=0, misalign=0, req_ready=1, stall=0.
//    RAM contents are not affected by reset.
//  - FSM states:
//    IDLE: ready=1. On accept (req_valid & req_ready), latch the request.
//          Go to WAIT if WAIT_CYCLES>0, otherwise to RESP.
//    WAIT: ready=0. Count WAIT_CYCLES cycles, then go to RESP.
//    RESP: resp_valid=1 for exactly one cycle; ready=1. Accept here -> WAIT/RESP as from IDLE; no accept -> IDLE.
//  - Latency: resp_valid is high WAIT_CYCLES+1 cycles after the accept edge.
//    Throughput: 1 request per WAIT_CYCLES+1 cycles; back-to-back every cycle when WAIT_CYCLES=0.
//  - RAM index = addr[ADDR_W+1:2]; higher address bits are ignored, so addresses wrap modulo the RAM size.
//  - Little-endian byte lanes selected by addr[1:0].
//    The store write and the load read both commit on the edge that raises resp_valid.
//    A request accepted in a store's RESP cycle therefore observes that store.
//  - Store byte enables: byte = 1 lane; half = lanes {a1,a1+1} with a1 = addr[1]*2; word = all 4 lanes.
//    Unselected bytes are preserved.
//  - Load: the selected lane(s) are shifted to bit 0 and extended per req_signed. req_signed is ignored for word loads.
//  - Misaligned = (half & addr[0]) | (word & addr[1:0]!=0) | size==11. misalign is asserted in the RESP cycle.
//    MISALIGN_TRAP=1: no RAM write; rdata=0; same latency as a normal access.
//    MISALIGN_TRAP=0: addr[1:0] is forced to 00 for word and addr[0] to 0 for half, then the access is performed.
//    size==11 always traps, regardless of MISALIGN_TRAP.
//  - Request inputs are sampled only at the accept edge; changes while in WAIT are ignored.
//  - Reset during WAIT or RESP: the pending store is dropped (RAM unchanged) and no resp_valid is produced.
//  - resp_rdata and misalign return to 0 in every cycle where resp_valid=0.
// TESTING
//  1. WAIT_CYCLES=0: SW 0xDEADBEEF @0x10, then LW @0x10 on the next cycle.
//     -> LW resp one cycle later returns 0xDEADBEEF; stall never asserted.
//  2. SB 0x80 @0x13, then LB @0x13 -> 0xFFFFFF80; LBU @0x13 -> 0x00000080; LW @0x10 -> 0x80ADBEEF.
//  3. WAIT_CYCLES=3: LW -> resp_valid 4 cycles after accept.
//     stall=1 for 3 cycles while req_valid is held; a second LW is accepted in the RESP cycle.
//  4. MISALIGN_TRAP=1: SH 0x1234 @0x11 -> misalign=1, rdata=0, word @0x10 unchanged.
//     With TRAP=0 the same SH writes lanes 0-1 -> LW @0x10 = 0x80AD1234.
//  5. ADDR_W=4: SW 0x55 @0x40 aliases word 0 -> LW @0x00 returns 0x00000055.
//  6. WAIT_CYCLES=2: assert RST low mid-WAIT during SW 0x1 @0x20.
//     -> no resp_valid, all outputs at reset values; LW @0x20 returns the old value.

Source files
------------

// File: rtl/pipe_lsu_mem.sv
// pipe_lsu_mem: MEM-stage load/store unit with word-organised data RAM, wait states and misalignment handling
module pipe_lsu_mem #(
  parameter int ADDR_W        = 10,
  parameter int WAIT_CYCLES   = 0,
  parameter bit MISALIGN_TRAP = 1
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic        i_req_we,
  input  logic [1:0]  i_req_size,
  input  logic        i_req_signed,
  input  logic [31:0] i_req_addr,
  input  logic [31:0] i_req_wdata,
  output logic        o_resp_valid,
  output logic [31:0] o_resp_rdata,
  output logic        o_misalign,
  output logic        o_stall
);
  localparam int AL = ADDR_W + 2;
  localparam bit LIVE = WAIT_CYCLES == 0;
  localparam logic [3:0] LAST = 4'(WAIT_CYCLES - 1);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t r_state, w_next;
  logic [3:0] r_cnt;
  logic r_we, r_signed, r_mis;
  logic [1:0] r_size;
  logic [AL-1:0] r_addr;
  logic [31:0] r_wdata, r_rdata;
  logic [31:0] r_mem [2**ADDR_W];
  logic w_accept, w_commit, w_we, w_sg, w_illegal, w_mis, w_trap, w_wr;
  logic [1:0] w_size, w_off;
  logic [AL-1:0] w_addr;
  logic [ADDR_W-1:0] w_idx;
  logic [3:0] w_be;
  logic [31:0] w_wdata, w_lane_d, w_sh, w_ext;
  assign o_req_ready = r_state != WAIT;
  assign o_stall = i_req_valid & ~o_req_ready;
  assign o_resp_valid = r_state == RESP;
  assign o_resp_rdata = r_rdata;
  assign o_misalign = r_mis;
  assign w_accept = i_req_valid & o_req_ready;
  // The access commits on the edge entering RESP; with no wait states that is the accept edge itself.
  assign w_commit = LIVE ? w_accept : (r_state == WAIT && r_cnt == LAST);
  assign w_we = LIVE ? i_req_we : r_we;
  assign w_size = LIVE ? i_req_size : r_size;
  assign w_sg = LIVE ? i_req_signed : r_signed;
  assign w_addr = LIVE ? i_req_addr[AL-1:0] : r_addr;
  assign w_wdata = LIVE ? i_req_wdata : r_wdata;
  assign w_illegal = w_size == 2'b11;
  assign w_mis = w_illegal | (w_size == 2'b01 & w_addr[0]) | (w_size == 2'b10 & |w_addr[1:0]);
  assign w_trap = w_illegal | (MISALIGN_TRAP & w_mis);
  assign w_off = w_size == 2'b10 ? 2'b00 : w_size == 2'b01 ? {w_addr[1], 1'b0} : w_addr[1:0];
  assign w_idx = w_addr[AL-1:2];
  assign w_be = w_size == 2'b00 ? 4'b0001 << w_off : w_size == 2'b01 ? 4'b0011 << w_off : 4'b1111;
  assign w_lane_d = w_wdata << {w_off, 3'b000};
  assign w_wr = w_commit & w_we & ~w_trap;
  assign w_sh = r_mem[w_idx] >> {w_off, 3'b000};
  assign w_ext = w_size == 2'b00 ? {{24{w_sg & w_sh[7]}}, w_sh[7:0]} :
                 w_size == 2'b01 ? {{16{w_sg & w_sh[15]}}, w_sh[15:0]} : w_sh;
  always_comb begin
    w_next = IDLE;
    if (r_state == WAIT) w_next = r_cnt == LAST ? RESP : WAIT;
    else if (w_accept) w_next = LIVE ? RESP : WAIT;
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_rdata  <= '0;
      r_mis    <= 1'b0;
      r_we     <= 1'b0;
      r_size   <= '0;
      r_signed <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
    end else begin
      r_state <= w_next;
      r_cnt   <= (r_state == WAIT && r_cnt != LAST) ? r_cnt + 4'd1 : 4'd0;
      r_rdata <= (w_commit & ~w_we & ~w_trap) ? w_ext : '0;
      r_mis   <= w_commit & w_mis;
      if (w_accept) begin
        r_we     <= i_req_we;
        r_size   <= i_req_size;
        r_signed <= i_req_signed;
        r_addr   <= i_req_addr[AL-1:0];
        r_wdata  <= i_req_wdata;
      end
    end
  end
  // RAM is not reset; a reset arriving on the commit edge drops the store.
  always_ff @(posedge i_clk) begin
    if (w_wr & i_rst_n)
      for (int b = 0; b < 4; b++)
        if (w_be[b]) r_mem[w_idx][8*b +: 8] <= w_lane_d[8*b +: 8];
  end
endmodule

// File: tb/tb_pipe_lsu_mem.sv
// tb_pipe_lsu_mem: three differently configured units driven by vector tables, corner sequences and random traffic
module tb_pipe_lsu_mem;
  function automatic int aw(int k); return k == 2 ? 4 : 10; endfunction
  function automatic int wc(int k); return k == 0 ? 0 : k == 1 ? 3 : 2; endfunction
  function automatic bit tr(int k); return k != 1; endfunction

  logic clk = 0;
  always #5 clk = ~clk;
  logic rst_n[3], v[3], we[3], sg[3], rdy[3], rv[3], ms[3], st[3];
  logic [1:0] sz[3];
  logic [31:0] ad[3], wd[3], rd[3];

  for (genvar g = 0; g < 3; g++) begin : u
    pipe_lsu_mem #(.ADDR_W(aw(g)), .WAIT_CYCLES(wc(g)), .MISALIGN_TRAP(tr(g))) dut (
      .i_clk(clk), .i_rst_n(rst_n[g]), .i_req_valid(v[g]), .o_req_ready(rdy[g]),
      .i_req_we(we[g]), .i_req_size(sz[g]), .i_req_signed(sg[g]), .i_req_addr(ad[g]),
      .i_req_wdata(wd[g]), .o_resp_valid(rv[g]), .o_resp_rdata(rd[g]), .o_misalign(ms[g]),
      .o_stall(st[g]));
  end

  int n_chk = 0, n_pass = 0, stall0 = 0;
  always @(negedge clk) if (st[0]) stall0++;

  task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", nm, got, exp);
  endtask

  bit [31:0] mm [3][1024];
  function automatic void model(int k, bit w, bit [1:0] s, bit sn, bit [31:0] a, bit [31:0] d,
                                output bit [31:0] r, output bit m);
    int nb = s == 0 ? 1 : s == 1 ? 2 : 4;
    int idx = int'((a >> 2) % (32'd1 << aw(k)));
    int off = int'(a % 4);
    bit [31:0] wv = mm[k][idx];
    r = 0;
    m = s == 3 || off % nb != 0;
    if (s == 3 || (m && tr(k))) return;
    off -= off % nb;
    for (int i = 0; i < nb; i++)
      if (w) wv[8*(off+i) +: 8] = d[8*i +: 8];
      else r[8*i +: 8] = wv[8*(off+i) +: 8];
    if (!w && sn && nb < 4 && r[8*nb-1]) r |= 32'hFFFFFFFF << (8*nb);
    mm[k][idx] = wv;
  endfunction

  task automatic txn(int k, bit w, bit [1:0] s, bit sn, bit [31:0] a, bit [31:0] d,
                     output logic [31:0] r, output logic m, output int lat);
    int n = 0;
    v[k] = 1; we[k] = w; sz[k] = s; sg[k] = sn; ad[k] = a; wd[k] = d;
    while (!rdy[k] && n < 40) begin @(negedge clk); n++; end
    @(negedge clk);
    v[k] = 0;
    lat = 1;
    while (!rv[k] && lat < 40) begin @(negedge clk); lat++; end
    r = rd[k];
    m = ms[k];
  endtask

  task automatic run(int k, string nm, bit w, bit [1:0] s, bit sn, bit [31:0] a, bit [31:0] d,
                     bit [31:0] er, bit em);
    logic [31:0] r;
    logic m;
    int lat;
    txn(k, w, s, sn, a, d, r, m, lat);
    chk({nm, " rdata"}, r, er);
    chk({nm, " misalign"}, 32'(m), 32'(em));
    chk({nm, " latency"}, lat, wc(k) + 1);
  endtask

  task automatic mrun(int k, string nm, bit w, bit [1:0] s, bit sn, bit [31:0] a, bit [31:0] d);
    bit [31:0] er;
    bit em;
    model(k, w, s, sn, a, d, er, em);
    run(k, nm, w, s, sn, a, d, er, em);
  endtask

  typedef struct {bit w; bit [1:0] s; bit sn; bit [31:0] a; bit [31:0] d; bit [31:0] er; bit em;} vec_t;
  vec_t tbl[18];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal;
  end

  initial begin
    bit [31:0] xr, ta;
    bit xm;
    bit [7:0] sp, rp;
    logic [31:0] d4, d8;
    int rvc;
    tbl[0]  = '{1, 2'd2, 0, 32'h10,   32'hDEADBEEF, 32'h0,        0};
    tbl[1]  = '{0, 2'd2, 0, 32'h10,   32'h0,        32'hDEADBEEF, 0};
    tbl[2]  = '{1, 2'd0, 0, 32'h13,   32'hFFFFFF80, 32'h0,        0};
    tbl[3]  = '{0, 2'd0, 1, 32'h13,   32'h0,        32'hFFFFFF80, 0};
    tbl[4]  = '{0, 2'd0, 0, 32'h13,   32'h0,        32'h00000080, 0};
    tbl[5]  = '{0, 2'd2, 0, 32'h10,   32'h0,        32'h80ADBEEF, 0};
    tbl[6]  = '{1, 2'd1, 0, 32'h11,   32'h1234,     32'h0,        1};
    tbl[7]  = '{0, 2'd2, 0, 32'h10,   32'h0,        32'h80ADBEEF, 0};
    tbl[8]  = '{0, 2'd1, 1, 32'h12,   32'h0,        32'hFFFF80AD, 0};
    tbl[9]  = '{0, 2'd1, 0, 32'h10,   32'h0,        32'h0000BEEF, 0};
    tbl[10] = '{0, 2'd1, 1, 32'h10,   32'h0,        32'hFFFFBEEF, 0};
    tbl[11] = '{0, 2'd0, 0, 32'h11,   32'h0,        32'h000000BE, 0};
    tbl[12] = '{0, 2'd0, 1, 32'h10,   32'h0,        32'hFFFFFFEF, 0};
    tbl[13] = '{0, 2'd3, 0, 32'h10,   32'h0,        32'h0,        1};
    tbl[14] = '{0, 2'd2, 0, 32'h12,   32'h0,        32'h0,        1};
    tbl[15] = '{1, 2'd1, 0, 32'h12,   32'hABCD5678, 32'h0,        0};
    tbl[16] = '{0, 2'd2, 1, 32'h10,   32'h0,        32'h5678BEEF, 0};
    tbl[17] = '{0, 2'd2, 0, 32'h1010, 32'h0,        32'h5678BEEF, 0};
    for (int k = 0; k < 3; k++) begin
      rst_n[k] = 0; v[k] = 0; we[k] = 0; sz[k] = 0; sg[k] = 0; ad[k] = 0; wd[k] = 0;
    end
    repeat (2) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("reset%0d rdy/rv/mis/stall", k), {28'd0, rdy[k], rv[k], ms[k], st[k]}, 32'h8);
      chk($sformatf("reset%0d rdata", k), rd[k], 32'h0);
      rst_n[k] = 1;
    end
    @(negedge clk);
    for (int i = 0; i < 18; i++) begin
      model(0, tbl[i].w, tbl[i].s, tbl[i].sn, tbl[i].a, tbl[i].d, xr, xm);
      run(0, $sformatf("vec%0d", i), tbl[i].w, tbl[i].s, tbl[i].sn, tbl[i].a, tbl[i].d, tbl[i].er, tbl[i].em);
    end
    chk("no stall at zero wait", stall0, 0);

    mrun(1, "w3 sw", 1, 2, 0, 32'h10, 32'h80ADBEEF);
    mrun(1, "w3 sw14", 1, 2, 0, 32'h14, 32'h0);
    v[1] = 1; we[1] = 0; sz[1] = 2; sg[1] = 0; ad[1] = 32'h10;
    sp = 0; rp = 0; d4 = 0; d8 = 0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      sp[c-1] = st[1];
      rp[c-1] = rv[1];
      if (c == 4) d4 = rd[1];
      if (c == 8) d8 = rd[1];
      if (c == 5) begin v[1] = 0; we[1] = 1; ad[1] = 32'h14; wd[1] = 32'hFFFFFFFF; end
    end
    chk("w3 stall pattern", 32'(sp), 32'h17);
    chk("w3 resp pattern", 32'(rp), 32'h88);
    chk("w3 first lw", d4, 32'h80ADBEEF);
    chk("w3 second lw", d8, 32'h80ADBEEF);
    run(1, "w3 wait-change ignored", 0, 2, 0, 32'h14, 0, 32'h0, 0);
    mrun(1, "notrap sh", 1, 1, 0, 32'h11, 32'h1234);
    run(1, "notrap lw", 0, 2, 0, 32'h10, 0, 32'h80AD1234, 0);
    mrun(1, "notrap lw mis", 0, 2, 0, 32'h13, 0);

    mrun(2, "alias sw", 1, 2, 0, 32'h40, 32'h55);
    run(2, "alias lw", 0, 2, 0, 32'h0, 0, 32'h55, 0);
    mrun(2, "old sw", 1, 2, 0, 32'h20, 32'hA5A5A5A5);
    v[2] = 1; we[2] = 1; sz[2] = 2; sg[2] = 0; ad[2] = 32'h20; wd[2] = 32'h1;
    @(negedge clk);
    rst_n[2] = 0;
    v[2] = 0;
    #1;
    chk("midwait reset rdy/rv/mis/stall", {28'd0, rdy[2], rv[2], ms[2], st[2]}, 32'h8);
    chk("midwait reset rdata", rd[2], 32'h0);
    rvc = 0;
    repeat (3) begin @(negedge clk); rvc += int'(rv[2]); end
    rst_n[2] = 1;
    repeat (4) begin @(negedge clk); rvc += int'(rv[2]); end
    chk("midwait reset no resp", rvc, 0);
    run(2, "dropped store", 0, 2, 0, 32'h20, 0, 32'hA5A5A5A5, 0);

    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 16; i++) begin
        ta = $urandom;
        mrun(k, "rnd init", 1, 2, 0, (ta & 32'hFFFFF000) | 32'(i * 4), $urandom);
      end
      for (int i = 0; i < 60; i++) begin
        ta = $urandom;
        mrun(k, $sformatf("rnd%0d.%0d", k, i), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
             1'($urandom_range(0, 1)), (ta & 32'hFFFFF000) | 32'($urandom_range(0, 63)), $urandom);
      end
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
